// File: rtl/adxl345_tilt_reader.sv
// adxl345_tilt_reader: SPI mode-3 master that configures an ADXL345 and
// periodically burst-reads DATAX0..DATAY1. The raw X/Y words are presented to
// the VGA drawing logic with a one-cycle update strobe.
//
// state  | meaning
// -------+-------------------------------------------------------------
// BOOT   | power-up delay before the first transaction
// INIT   | one 16-bit configuration write on the bus
// WAIT   | idle, poll timer counting down to the next read
// READ   | one 40-bit burst read (command byte + X0, X1, Y0, Y1)
// GAP    | CSN held high between transactions, then pick the next one
module adxl345_tilt_reader #(
  parameter int SCLK_DIV    = 25,
  parameter int BOOT_CYCLES = 100000,
  parameter int POLL_CYCLES = 500000
) (
  input  logic        iCLK,
  input  logic        iRST,
  output logic        oSPI_CSN,
  output logic        oSPI_SCLK,
  output logic        oSPI_SDI,
  input  logic        iSPI_SDO,
  output logic [15:0] oTILT_X,
  output logic [15:0] oTILT_Y,
  output logic        oVALID,
  output logic        oINIT_DONE
);

  localparam logic [2:0] S_BOOT = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_READ = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  // Half-period counter also times the 2*SCLK_DIV gap, so it is sized for that.
  localparam int DIV_W  = $clog2(2 * SCLK_DIV);
  localparam int BOOT_W = $clog2(BOOT_CYCLES + 1);
  localparam int POLL_W = $clog2(POLL_CYCLES + 1);

  localparam logic [DIV_W-1:0]  HALF_LOAD = DIV_W'(SCLK_DIV - 1);
  localparam logic [DIV_W-1:0]  GAP_LOAD  = DIV_W'(2 * SCLK_DIV - 1);
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);
  localparam logic [POLL_W-1:0] POLL_LOAD = POLL_W'(POLL_CYCLES - 1);

  // Edge budget per transaction: one SCLK fall and one rise per bit.
  localparam logic [6:0] WR_EDGES = 7'd32;
  localparam logic [6:0] RD_EDGES = 7'd80;
  // R=1, MB=1, start address 0x32 (DATAX0).
  localparam logic [7:0] RD_CMD   = 8'hF2;

  // Configuration writes {R/W=0, MB=0, addr[5:0], data[7:0]}, issued in order.
  function automatic logic [15:0] init_word(input logic [1:0] idx);
    logic [15:0] w;
    case (idx)
      2'd0:    w = 16'h3108;  // DATA_FORMAT: full-res, 4-wire, +/-2g
      2'd1:    w = 16'h2C0A;  // BW_RATE: 100 Hz
      default: w = 16'h2D08;  // POWER_CTL: measure
    endcase
    return w;
  endfunction

  logic [2:0]        state_q,     state_d;
  logic [BOOT_W-1:0] boot_cnt_q,  boot_cnt_d;
  logic [DIV_W-1:0]  div_q,       div_d;
  logic [6:0]        edges_q,     edges_d;
  logic [POLL_W-1:0] poll_q,      poll_d;
  logic [1:0]        wr_idx_q,    wr_idx_d;
  logic              init_done_q, init_done_d;
  logic              csn_q,       csn_d;
  logic              sclk_q,      sclk_d;
  logic              sdi_q,       sdi_d;
  logic [39:0]       tx_q,        tx_d;
  logic [31:0]       rx_q,        rx_d;
  logic              sdo_meta_q,  sdo_meta_d;
  logic              sdo_sync_q,  sdo_sync_d;
  logic              upd_pend_q,  upd_pend_d;
  logic              valid_q,     valid_d;
  logic [15:0]       tilt_x_q,    tilt_x_d;
  logic [15:0]       tilt_y_q,    tilt_y_d;

  logic start_wr;
  logic start_rd;

  // Next-state logic: sequencer, shift engine, poll timer and output update.
  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    div_d       = div_q;
    edges_d     = edges_q;
    wr_idx_d    = wr_idx_q;
    init_done_d = init_done_q;
    csn_d       = csn_q;
    sclk_d      = sclk_q;
    sdi_d       = sdi_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    tilt_x_d    = tilt_x_q;
    tilt_y_d    = tilt_y_q;
    valid_d     = 1'b0;
    upd_pend_d  = 1'b0;
    start_wr    = 1'b0;
    start_rd    = 1'b0;

    sdo_meta_d  = iSPI_SDO;
    sdo_sync_d  = sdo_meta_q;

    // The poll timer free-runs down to zero and parks there; zero means
    // "a read is due" and is honoured at the next safe point.
    poll_d = (poll_q != '0) ? poll_q - 1'b1 : poll_q;

    // Capture register holds X0,X1,Y0,Y1 MSB-first; bytes are swapped into
    // {X1,X0} / {Y1,Y0} with no other manipulation.
    if (upd_pend_q) begin
      valid_d  = 1'b1;
      tilt_x_d = {rx_q[23:16], rx_q[31:24]};
      tilt_y_d = {rx_q[7:0],   rx_q[15:8]};
    end

    case (state_q)
      S_BOOT: begin
        if (boot_cnt_q == BOOT_LAST) begin
          start_wr = 1'b1;
        end else begin
          boot_cnt_d = boot_cnt_q + 1'b1;
        end
      end

      S_INIT, S_READ: begin
        if (div_q != '0) begin
          div_d = div_q - 1'b1;
        end else begin
          div_d = HALF_LOAD;
          if (edges_q == 7'd0) begin
            // All bits done: release CSN half a period after the last rise.
            csn_d      = 1'b1;
            sdi_d      = 1'b0;
            div_d      = GAP_LOAD;
            state_d    = S_GAP;
            upd_pend_d = (state_q == S_READ);
          end else begin
            edges_d = edges_q - 7'd1;
            if (!edges_q[0]) begin
              // Falling edge: present the next MOSI bit.
              sclk_d = 1'b0;
              sdi_d  = tx_q[39];
            end else begin
              // Rising edge: slave samples MOSI, we sample synchronized MISO.
              sclk_d = 1'b1;
              tx_d   = {tx_q[38:0], 1'b0};
              rx_d   = {rx_q[30:0], sdo_sync_q};
            end
          end
        end
      end

      S_WAIT: begin
        if (poll_q == '0) begin
          start_rd = 1'b1;
        end
      end

      S_GAP: begin
        if (div_q != '0) begin
          div_d = div_q - 1'b1;
        end else if (!init_done_q) begin
          if (wr_idx_q == 2'd2) begin
            init_done_d = 1'b1;
            start_rd    = 1'b1;
          end else begin
            wr_idx_d = wr_idx_q + 2'd1;
            start_wr = 1'b1;
          end
        end else if (poll_q == '0) begin
          start_rd = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase

    if (start_wr) begin
      state_d = S_INIT;
      tx_d    = {init_word(wr_idx_d), 24'h0};
      edges_d = WR_EDGES;
    end

    if (start_rd) begin
      state_d = S_READ;
      tx_d    = {RD_CMD, 32'h0};
      edges_d = RD_EDGES;
      poll_d  = POLL_LOAD;
    end

    // Transaction start: CSN falls with SCLK idle high and the MSB already on MOSI.
    if (start_wr || start_rd) begin
      csn_d  = 1'b0;
      sclk_d = 1'b1;
      sdi_d  = tx_d[39];
      div_d  = HALF_LOAD;
    end
  end

  // State registers; reset drops CSN/SCLK high and discards any partial capture.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q     <= S_BOOT;
      boot_cnt_q  <= '0;
      div_q       <= '0;
      edges_q     <= '0;
      poll_q      <= '0;
      wr_idx_q    <= '0;
      init_done_q <= 1'b0;
      csn_q       <= 1'b1;
      sclk_q      <= 1'b1;
      sdi_q       <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      sdo_meta_q  <= 1'b0;
      sdo_sync_q  <= 1'b0;
      upd_pend_q  <= 1'b0;
      valid_q     <= 1'b0;
      tilt_x_q    <= '0;
      tilt_y_q    <= '0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      div_q       <= div_d;
      edges_q     <= edges_d;
      poll_q      <= poll_d;
      wr_idx_q    <= wr_idx_d;
      init_done_q <= init_done_d;
      csn_q       <= csn_d;
      sclk_q      <= sclk_d;
      sdi_q       <= sdi_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      sdo_meta_q  <= sdo_meta_d;
      sdo_sync_q  <= sdo_sync_d;
      upd_pend_q  <= upd_pend_d;
      valid_q     <= valid_d;
      tilt_x_q    <= tilt_x_d;
      tilt_y_q    <= tilt_y_d;
    end
  end

  assign oSPI_CSN   = csn_q;
  assign oSPI_SCLK  = sclk_q;
  assign oSPI_SDI   = sdi_q;
  assign oTILT_X    = tilt_x_q;
  assign oTILT_Y    = tilt_y_q;
  assign oVALID     = valid_q;
  assign oINIT_DONE = init_done_q;

endmodule

// File: tb/tb_adxl345_tilt_reader.sv
// Bench for adxl345_tilt_reader: two instances (normal poll period and
// back-to-back polling), each with a mode-3 ADXL345 slave model that logs
// every CSN-low window.
module tb_adxl345_tilt_reader;

  localparam int SD     = 8;
  localparam int LOGN   = 64;
  localparam int RD_LEN = 83 * SD;

  typedef struct {
    logic [7:0]  x0, x1, y0, y1;
    logic [15:0] ex, ey;
  } rd_vec_t;

  logic        clk = 1'b0;
  logic [1:0]  rst_v = 2'b11;
  logic [1:0]  sdo_v = 2'b00;

  logic        a_csn, a_sclk, a_sdi, a_valid, a_idone;
  logic [15:0] a_tx, a_ty;
  logic        b_csn, b_sclk, b_sdi, b_valid, b_idone;
  logic [15:0] b_tx, b_ty;

  logic [1:0]  csn_v, sclk_v, sdi_v, valid_v;
  assign csn_v   = {b_csn, a_csn};
  assign sclk_v  = {b_sclk, a_sclk};
  assign sdi_v   = {b_sdi, a_sdi};
  assign valid_v = {b_valid, a_valid};

  adxl345_tilt_reader #(.SCLK_DIV(SD), .BOOT_CYCLES(100), .POLL_CYCLES(2000)) dut (
    .iCLK(clk), .iRST(rst_v[0]), .oSPI_CSN(a_csn), .oSPI_SCLK(a_sclk),
    .oSPI_SDI(a_sdi), .iSPI_SDO(sdo_v[0]), .oTILT_X(a_tx), .oTILT_Y(a_ty),
    .oVALID(a_valid), .oINIT_DONE(a_idone));

  adxl345_tilt_reader #(.SCLK_DIV(SD), .BOOT_CYCLES(100), .POLL_CYCLES(100)) dut_b2b (
    .iCLK(clk), .iRST(rst_v[1]), .oSPI_CSN(b_csn), .oSPI_SCLK(b_sclk),
    .oSPI_SDI(b_sdi), .iSPI_SDO(sdo_v[1]), .oTILT_X(b_tx), .oTILT_Y(b_ty),
    .oVALID(b_valid), .oINIT_DONE(b_idone));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model state and transaction log, per instance.
  int          ntx[2];
  int          lg_start[2][LOGN];
  int          lg_end[2][LOGN];
  int          lg_bits[2][LOGN];
  logic [39:0] lg_mosi[2][LOGN];
  int          cur_bits[2];
  logic [39:0] cur_mosi[2];
  int          cur_start[2];
  int          last_edge[2];
  logic [31:0] resp[2];
  int          hp_err[2];
  int          vt_err[2];
  int          vcnt[2];
  int          hold_err = 0;
  logic [15:0] p_tx = 16'h0, p_ty = 16'h0;
  logic [1:0]  p_csn = 2'b11, p_sclk = 2'b11, p_valid = 2'b00;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Mode-3 slave: everything sampled on the falling iCLK edge, well away from
  // the DUT's active edge; MISO changes after each SCLK fall.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (p_csn[i] && !csn_v[i]) begin
        cur_bits[i]  = 0;
        cur_mosi[i]  = '0;
        cur_start[i] = cyc;
        last_edge[i] = cyc;
      end else if (!p_csn[i] && csn_v[i]) begin
        if (!rst_v[i] && (cyc - last_edge[i] != SD)) hp_err[i]++;
        if (ntx[i] < LOGN) begin
          lg_start[i][ntx[i]] = cur_start[i];
          lg_end[i][ntx[i]]   = cyc;
          lg_bits[i][ntx[i]]  = cur_bits[i];
          lg_mosi[i][ntx[i]]  = cur_mosi[i];
          ntx[i]++;
        end
      end
      if (!csn_v[i] && !p_csn[i]) begin
        if (p_sclk[i] && !sclk_v[i]) begin
          if (cyc - last_edge[i] != SD) hp_err[i]++;
          last_edge[i] = cyc;
          if (cur_bits[i] >= 8 && cur_bits[i] < 40) sdo_v[i] = resp[i][39 - cur_bits[i]];
          else sdo_v[i] = 1'b0;
        end else if (!p_sclk[i] && sclk_v[i]) begin
          if (cyc - last_edge[i] != SD) hp_err[i]++;
          last_edge[i] = cyc;
          cur_mosi[i] = {cur_mosi[i][38:0], sdi_v[i]};
          cur_bits[i]++;
        end
      end
      if (valid_v[i]) begin
        vcnt[i]++;
        if (p_valid[i] || ntx[i] == 0 || lg_end[i][ntx[i]-1] != cyc - 1 ||
            lg_bits[i][ntx[i]-1] != 40)
          vt_err[i]++;
      end
    end
    if (!rst_v[0] && !a_valid && (a_tx != p_tx || a_ty != p_ty)) hold_err++;
    p_tx    = a_tx;
    p_ty    = a_ty;
    p_csn   = csn_v;
    p_sclk  = sclk_v;
    p_valid = valid_v;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
  endtask

  task automatic check_range(input string nm, input int act, input int lo, input int hi);
    chk_cnt++;
    if (act >= lo && act <= hi) pass_cnt++;
    else $display("FAIL %s: actual=%0d required=%0d..%0d", nm, act, lo, hi);
  endtask

  // From reset release: outputs must stay at reset values until the first CSN fall.
  task automatic boot_phase(input int rel);
    int n   = 0;
    int bad = 0;
    while (a_csn && n < 400) begin
      @(negedge clk); #1;
      n++;
      if (a_csn && {a_sclk, a_sdi, a_valid, a_idone, a_tx, a_ty} !== {4'b1000, 32'h0}) bad++;
    end
    check("boot_hold", 64'(bad), 64'(0));
    check_range("first_csn_fall", cyc - rel, 99, 101);
  endtask

  task automatic wait_idone();
    int n = 0;
    while (!a_idone && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    check("init_done_seen", 64'(a_idone), 64'(1));
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!a_valid && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    check("valid_seen", 64'(a_valid), 64'(1));
  endtask

  task automatic check_init(input int base);
    logic [15:0] iw[3];
    iw[0] = 16'h3108;
    iw[1] = 16'h2C0A;
    iw[2] = 16'h2D08;
    check("init_tx_count", 64'(ntx[0] - base), 64'(3));
    for (int k = 0; k < 3; k++)
      check($sformatf("init_word%0d", k),
            {32'h0, lg_bits[0][base+k][15:0], lg_mosi[0][base+k][15:0]},
            {32'h0, 16'd16, iw[k]});
    check("init_done_at_read_fall", 64'(cur_start[0]), 64'(cyc));
  endtask

  rd_vec_t vecs[4];

  initial begin
    int rel, base, vsave, bad, pairs, n, nr;

    vecs[0] = '{8'h34, 8'hFF, 8'h12, 8'h80, 16'hFF34, 16'h8012};
    vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h0000};
    vecs[2] = '{8'hFF, 8'h7F, 8'h01, 8'h80, 16'h7FFF, 16'h8001};
    vecs[3] = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 16'h5AA5, 16'h3CC3};

    resp[0] = {vecs[0].x0, vecs[0].x1, vecs[0].y0, vecs[0].y1};
    resp[1] = 32'h0102_0304;
    rst_v   = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    check("reset_a", 64'({a_csn, a_sclk, a_sdi, a_valid, a_idone, a_tx, a_ty}),
          64'({5'b11000, 32'h0}));
    check("reset_b", 64'({b_csn, b_sclk, b_sdi, b_valid, b_idone, b_tx, b_ty}),
          64'({5'b11000, 32'h0}));

    rst_v = 2'b00;
    rel   = cyc;
    boot_phase(rel);
    wait_idone();
    check_init(0);

    // Table-driven reads: new model data must only appear at the next oVALID.
    for (int v = 0; v < 4; v++) begin
      wait_valid();
      check($sformatf("tilt_vec%0d", v), 64'({a_tx, a_ty}), 64'({vecs[v].ex, vecs[v].ey}));
      if (v == 0)
        check("read_cmd_bits", {32'h0, lg_bits[0][ntx[0]-1][7:0], lg_mosi[0][ntx[0]-1][39:32]},
              {32'h0, 8'd40, 8'hF2});
      if (v < 3) resp[0] = {vecs[v+1].x0, vecs[v+1].x1, vecs[v+1].y0, vecs[v+1].y1};
      repeat (50) @(negedge clk);
      #1;
      check($sformatf("hold_after_change%0d", v), 64'({a_tx, a_ty}),
            64'({vecs[v].ex, vecs[v].ey}));
    end

    bad   = 0;
    pairs = 0;
    for (int j = 4; j < ntx[0]; j++) begin
      pairs++;
      if (lg_start[0][j] - lg_start[0][j-1] != 2000 || lg_bits[0][j] != 40) bad++;
    end
    check("poll_period", 64'(bad), 64'(0));
    check("poll_pairs", 64'(pairs >= 3), 64'(1));
    check("hold_monitor", 64'(hold_err), 64'(0));
    check("valid_timing_a", 64'(vt_err[0]), 64'(0));
    check("sclk_half_period_a", 64'(hp_err[0]), 64'(0));

    // Reset during bit 20 of a read.
    n = 0;
    while (!(!a_csn && cur_bits[0] == 20 && cur_mosi[0][19:12] == 8'hF2) && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    check("reached_bit20", 64'(cur_bits[0]), 64'(20));
    check("pre_rst_tilt", 64'({a_tx, a_ty}), 64'({16'h5AA5, 16'h3CC3}));
    vsave = vcnt[0];
    #1;
    rst_v[0] = 1'b1;
    #1;
    check("rst_async", 64'({a_csn, a_sclk, a_valid, a_tx, a_ty}), 64'({3'b110, 32'h0}));
    repeat (5) @(negedge clk);
    #1;
    rst_v[0] = 1'b0;
    rel      = cyc;
    base     = ntx[0];
    check("partial_logged_bits", 64'(lg_bits[0][base-1]), 64'(20));
    boot_phase(rel);
    wait_idone();
    check_init(base);
    check("no_valid_across_reset", 64'(vcnt[0]), 64'(vsave));
    wait_valid();
    check("reread_tilt", 64'({a_tx, a_ty}), 64'({16'h5AA5, 16'h3CC3}));

    // Back-to-back instance: inspect its log while it is mid-transaction.
    n = 0;
    while (b_csn && n < 1000) begin
      @(negedge clk); #1;
      n++;
    end
    bad = 0;
    for (int j = 3; j < ntx[1]; j++) begin
      if (lg_bits[1][j] != 40 || lg_mosi[1][j][39:32] != 8'hF2) bad++;
      if (j > 3 && (lg_start[1][j] - lg_end[1][j-1] != 2 * SD ||
                    lg_start[1][j] - lg_start[1][j-1] != RD_LEN)) bad++;
    end
    nr = ntx[1] - 3;
    check("b2b_reads", 64'(bad), 64'(0));
    check("b2b_read_count", 64'(nr >= 5), 64'(1));
    check("b2b_valid_count", 64'(vcnt[1]), 64'(nr));
    check("b2b_valid_timing", 64'(vt_err[1]), 64'(0));
    check("b2b_half_period", 64'(hp_err[1]), 64'(0));
    check("b2b_tilt", 64'({b_tx, b_ty}), 64'({16'h0201, 16'h0403}));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/adxl345_tilt_reader.md
# adxl345_tilt_reader

SPI master that initialises an ADXL345 accelerometer and periodically burst-reads its X and Y data registers. It presents the raw signed 16-bit samples as tilt words to the VGA drawing logic (the iTILT_X/iTILT_Y consumer) together with a one-cycle update strobe. It sits between the board accelerometer pins and the display pipeline, in the same iCLK domain as the VGA block.

## Interface

- SCLK_DIV, 25: SCLK half-period in iCLK cycles. The minimum is 8; the default gives 1 MHz at 50 MHz.
- BOOT_CYCLES, 100000: delay after reset before the first transaction (2 ms at 50 MHz).
- POLL_CYCLES, 500000: start-to-start read period (100 Hz). Must exceed one read transaction (83*SCLK_DIV cycles).
- iCLK  in  1  system clock
- iRST  in  1  reset, asynchronous, active-high
- oSPI_CSN  out  1  chip select, active low
- oSPI_SCLK  out  1  SPI clock, mode 3 (idle high)
- oSPI_SDI  out  1  MOSI
- iSPI_SDO  in  1  MISO, asynchronous to iCLK
- oTILT_X  out  16  {DATAX1, DATAX0}, two's complement, passed through unchanged
- oTILT_Y  out  16  {DATAY1, DATAY0}, two's complement
- oVALID  out  1  one-cycle pulse when oTILT_X/oTILT_Y update
- oINIT_DONE  out  1  high once the init writes complete; sticky until reset

## Operation

- Reset values: oSPI_CSN=1, oSPI_SCLK=1, oSPI_SDI=0, oTILT_X=0, oTILT_Y=0, oVALID=0, oINIT_DONE=0. The FSM enters BOOT and all counters clear.
- **FSM states**:
  - BOOT: counts BOOT_CYCLES, then goes to INIT.
  - INIT: issues three 16-bit writes in order. Each write uses the bit layout {R/W=0, MB=0, addr[5:0], data[7:0]}.
    - 0x3108: DATA_FORMAT, full-res, 4-wire, ±2g.
    - 0x2C0A: BW_RATE, 100 Hz.
    - 0x2D08: POWER_CTL, measure.
  - INIT exit: after the third write's gap, oINIT_DONE is set, the poll timer loads, and a read starts immediately. The FSM moves to READ.
  - WAIT: poll timer counts down. At expiry the FSM goes to READ.
  - READ: one 40-bit transaction.
    - Command byte 0xF2 (R=1, MB=1, addr 0x32) is sent, then 32 bits with oSPI_SDI=0.
    - The received bytes, in order, are X0, X1, Y0, Y1.
  - GAP: CSN is held high for the inter-transaction gap, then the FSM returns to INIT (next write), WAIT, or READ.
- Poll timer: reloads with POLL_CYCLES at the cycle each READ transaction starts. If it expires during READ or GAP, the next READ begins immediately after GAP. Transactions never overlap.
- Shift engine:
  - MOSI is shifted out MSB first.
  - MISO is shifted in MSB first per byte, into a 32-bit capture register.
  - Bit counter covers 16 or 40 bits.
- iSPI_SDO passes through a 2-FF synchronizer before sampling.
- Output update: X and Y update atomically, only at the end of a complete READ. Between reads the outputs hold their values. No filtering and no sign manipulation is applied.
- Reset mid-transaction: oSPI_CSN and oSPI_SCLK go high asynchronously. Outputs clear, the partial capture is discarded, and the sequence restarts from BOOT, including the re-init writes.

## Timing

- Transaction of N bits starting at cycle T0, with D = SCLK_DIV:
  - T0: CSN falls; SCLK=1; SDI = bit N-1.
  - Bit k, for k = 0..N-1:
    - SCLK falls at T0+(2k+1)D, with SDI updated on the same cycle to bit N-1-k.
    - SCLK rises at T0+(2k+2)D. The synchronized SDO is captured on that same iCLK edge.
  - CSN rises at T0+(2N+1)D.
- GAP: CSN stays high for 2D cycles. The next CSN fall is no earlier than T0+(2N+3)D.
- Durations: a write lasts 35D cycles from CSN fall to end of gap; a read lasts 83D.
- oVALID is high for exactly one cycle: the cycle after CSN rises at the end of a READ. oTILT_X/oTILT_Y take their new values on that same cycle.
- oINIT_DONE rises at the end of the third write's GAP. That is the same cycle the first READ CSN falls.
- First CSN fall after reset release occurs at cycle BOOT_CYCLES (±1).

## Test plan

Bench parameters: SCLK_DIV=8, BOOT_CYCLES=100, POLL_CYCLES=2000. The ADXL345 slave model is mode 3.

- **Reset/boot**: assert iRST, release. All outputs hold their reset values and CSN stays high for 100 cycles. The first CSN fall occurs at cycle 100±1.
- **Init sequence**: the model captures exactly three 16-bit MOSI words: 0x3108, 0x2C0A, 0x2D08. SCLK half-period is 8 cycles, and the SCLK count per CSN-low window is 16. oINIT_DONE rises at the third gap end.
- **Read decode**: model returns X0=0x34, X1=0xFF, Y0=0x12, Y1=0x80.
  - Captured command byte is 0xF2 and the transaction has 40 SCLKs.
  - oTILT_X=0xFF34, oTILT_Y=0x8012, with oVALID pulsed for one cycle right after CSN rises.
- **Poll period/hold**: consecutive read CSN falls are exactly 2000 cycles apart. Outputs are constant between oVALID pulses. Changing model data updates the outputs only at the next oVALID.
- **Reset mid-read**: assert iRST during bit 20 of a READ. CSN and SCLK go to 1 and oTILT_X/oTILT_Y go to 0 without waiting for a clock edge, and no oVALID is produced. After release, the full BOOT plus three-write init repeats.
- **Back-to-back**: with POLL_CYCLES=100 (less than 664), reads are still separated by a 16-cycle CSN-high gap. Each read still produces exactly one oVALID, and no transaction is truncated.
